ddr2pe_unpack: RTL and testbench

//  - Read-side counterpart of the PE-to-DDR writeback path.
//  - Accepts DDR read-data beats (DDR_W wide) from the DDR read channel over a valid/ready handshake.
//  - Splits each beat into SEG_NUM = DDR_W/BUF_W segments and writes them, one per cycle, into the PE-group buffers.
//  - Address and group sequencing interleave successive segment runs across GRP_NUM PE groups.

---
 rtl/ddr2pe_unpack.sv | 154 +++++++++++++++
 tb/tb_ddr2pe_unpack.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2pe_unpack.sv
// DDR read-beat unpacker: splits DDR_W beats into BUF_W segments and
// writes them one per cycle into GRP_NUM PE-group buffers.
// Ports: clk, rst (async active-low), start/done, conf_* run setup,
//   ddr_data/valid/ready read channel, buf_wr_sel/addr/data/en write port.
// Option: DDR2PE_STALL_CNT_EN adds stall_cnt[31:0] (starved RUN cycles).
module ddr2pe_unpack #(
   parameter int BUF_DEPTH = 256,
   parameter int ADDR_W    = $clog2(BUF_DEPTH),
   parameter int DDR_W     = 512,
   parameter int BUF_W     = 128,
   parameter int GRP_NUM   = 4,
   parameter int SEL_W     = (GRP_NUM > 1) ? $clog2(GRP_NUM) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              done,
   input  logic [ADDR_W-1:0] conf_st_addr,
   input  logic [ADDR_W-1:0] conf_grp_len,
   input  logic [SEL_W-1:0]  conf_grp_num,
   input  logic [15:0]       conf_seg_num,
   input  logic [DDR_W-1:0]  ddr_data,
   input  logic              ddr_valid,
   output logic              ddr_ready,
   output logic [SEL_W-1:0]  buf_wr_sel,
   output logic [ADDR_W-1:0] buf_wr_addr,
   output logic [BUF_W-1:0]  buf_wr_data,
   output logic              buf_wr_en
`ifdef DDR2PE_STALL_CNT_EN
   ,
   output logic [31:0]       stall_cnt
`endif
);

   localparam int SEG_NUM = DDR_W / BUF_W;
   localparam int CNT_W   = $clog2(SEG_NUM + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state, state_nxt;
   logic [DDR_W-1:0]  hold_data;
   logic [CNT_W-1:0]  hold_cnt;
   logic [CNT_W-1:0]  load_cnt;
   logic [15:0]       unreq;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] nxt_addr;
   logic [ADDR_W-1:0] run_last;
   logic [SEL_W-1:0]  nxt_sel;
   logic [ADDR_W-1:0] grp_len;
   logic [SEL_W-1:0]  grp_num;
   logic              start_ok;
   logic              emit;
   logic              accept;

   // unreq counts segments not yet loaded into the hold register
   assign start_ok = (state == IDLE) && start;
   assign emit     = (state == RUN) && (hold_cnt != '0);
   assign accept   = ddr_valid && ddr_ready;
   assign run_last = base + grp_len - ADDR_W'(1);
   assign load_cnt = (unreq >= 16'(SEG_NUM)) ? CNT_W'(SEG_NUM)
                                             : unreq[CNT_W-1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ddr_ready = 1'b0;
      unique case (state)
         IDLE: begin
            if (start)
               state_nxt = (conf_seg_num == '0) ? DONE : RUN;
         end
         RUN: begin
            // refill only when the held beat is empty or draining its last
            ddr_ready = (unreq != '0) && (hold_cnt <= CNT_W'(1));
            // last write is visible now; nothing left anywhere
            if (buf_wr_en && unreq == '0 && hold_cnt == '0)
               state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done        <= 1'b0;
         buf_wr_en   <= 1'b0;
         buf_wr_sel  <= '0;
         buf_wr_addr <= '0;
         buf_wr_data <= '0;
         hold_data   <= '0;
         hold_cnt    <= '0;
         unreq       <= '0;
         base        <= '0;
         nxt_addr    <= '0;
         nxt_sel     <= '0;
         grp_len     <= '0;
         grp_num     <= '0;
      end else begin
         done      <= (state_nxt == DONE);
         buf_wr_en <= emit;
         if (start_ok) begin
            grp_len  <= conf_grp_len;
            grp_num  <= conf_grp_num;
            base     <= conf_st_addr;
            nxt_addr <= conf_st_addr;
            nxt_sel  <= '0;
            unreq    <= conf_seg_num;
         end
         if (emit) begin
            buf_wr_data <= hold_data[BUF_W-1:0];
            buf_wr_sel  <= nxt_sel;
            buf_wr_addr <= nxt_addr;
            hold_data   <= hold_data >> BUF_W;
            hold_cnt    <= hold_cnt - CNT_W'(1);
            if (nxt_addr == run_last) begin
               if (nxt_sel == grp_num) begin
                  nxt_sel  <= '0;
                  base     <= base + grp_len;
                  nxt_addr <= base + grp_len;
               end else begin
                  nxt_sel  <= nxt_sel + SEL_W'(1);
                  nxt_addr <= base;
               end
            end else begin
               nxt_addr <= nxt_addr + ADDR_W'(1);
            end
         end
         // a new beat overrides the drained hold contents
         if (accept) begin
            hold_data <= ddr_data;
            hold_cnt  <= load_cnt;
            unreq     <= unreq - 16'(load_cnt);
         end
      end
   end

`ifdef DDR2PE_STALL_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         stall_cnt <= '0;
      else if (start_ok)
         stall_cnt <= '0;
      else if (state == RUN && hold_cnt == '0 && !ddr_valid
               && stall_cnt != '1)
         stall_cnt <= stall_cnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_ddr2pe_unpack.sv
// Scoreboard bench for ddr2pe_unpack: random beats, reference write list
// built from run/group arithmetic, monitor pops on every buf_wr_en.
module tb_ddr2pe_unpack;

   localparam int DDR_W = 512;
   localparam int BUF_W = 128;
   localparam int SEG   = DDR_W / BUF_W;

   logic              clk = 0;
   logic              rst = 0;
   logic              start = 0;
   logic              done;
   logic [7:0]        conf_st_addr = '0;
   logic [7:0]        conf_grp_len = '0;
   logic [1:0]        conf_grp_num = '0;
   logic [15:0]       conf_seg_num = '0;
   logic [DDR_W-1:0]  ddr_data = '0;
   logic              ddr_valid = 0;
   logic              ddr_ready;
   logic [1:0]        buf_wr_sel;
   logic [7:0]        buf_wr_addr;
   logic [BUF_W-1:0]  buf_wr_data;
   logic              buf_wr_en;
`ifdef DDR2PE_STALL_CNT_EN
   logic [31:0]       stall_cnt;
`endif

   ddr2pe_unpack dut (
      .clk(clk), .rst(rst), .start(start), .done(done),
      .conf_st_addr(conf_st_addr), .conf_grp_len(conf_grp_len),
      .conf_grp_num(conf_grp_num), .conf_seg_num(conf_seg_num),
      .ddr_data(ddr_data), .ddr_valid(ddr_valid), .ddr_ready(ddr_ready),
      .buf_wr_sel(buf_wr_sel), .buf_wr_addr(buf_wr_addr),
      .buf_wr_data(buf_wr_data), .buf_wr_en(buf_wr_en)
`ifdef DDR2PE_STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]       sel;
      logic [7:0]       addr;
      logic [BUF_W-1:0] data;
   } exp_t;

   exp_t             expq[$];
   logic [DDR_W-1:0] beats[$];
   int  vecs = 0, errs = 0;
   int  cyc = 0;
   int  idx = 0, mode = 0, acc_cnt = 0, first_acc = -1;
   bit  drv_en = 0, ready_seen = 0;
   int  first_wr = -1, last_wr = -1, wr_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string nm, logic [BUF_W-1:0] act,
                      logic [BUF_W-1:0] req);
      vecs++;
      if (act !== req) begin
         errs++;
         $display("FAIL %s got %0h expected %0h", nm, act, req);
      end
   endtask

   // driver: presents beats, advances on a handshake seen before the edge
   initial begin
      bit acc;
      forever begin
         @(negedge clk);
         acc = rst && ddr_valid && ddr_ready;
         if (rst && ddr_ready) ready_seen = 1;
         if (acc) begin
            if (acc_cnt == 0) first_acc = cyc;
            acc_cnt++;
         end
         @(posedge clk);
         #1;
         if (acc) idx++;
         if (drv_en && idx < beats.size()) begin
            case (mode)
               0:       ddr_valid = 1'b1;
               1:       ddr_valid = ((cyc / 5) % 2) == 0;
               default: ddr_valid = 1'($urandom_range(0, 1));
            endcase
            ddr_data = beats[idx];
         end else begin
            ddr_valid = 1'b0;
         end
      end
   end

   // monitor: every buffer write is checked against the scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst && buf_wr_en) begin
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            wr_cnt++;
            vecs++;
            if (expq.size() == 0) begin
               errs++;
               $display("FAIL extra_write sel=%0d addr=%0d data=%0h",
                        buf_wr_sel, buf_wr_addr, buf_wr_data);
            end else begin
               e = expq.pop_front();
               if (buf_wr_sel !== e.sel || buf_wr_addr !== e.addr ||
                   buf_wr_data !== e.data) begin
                  errs++;
                  $display("FAIL write got (%0d,%0d,%0h) expected (%0d,%0d,%0h)",
                           buf_wr_sel, buf_wr_addr, buf_wr_data,
                           e.sel, e.addr, e.data);
               end
            end
         end
      end
   end

   int scyc;

   task automatic launch(int st, int len, int gn, int seg, int md);
      int nb;
      logic [DDR_W-1:0] w;
      exp_t e;
      nb = (seg + SEG - 1) / SEG;
      beats.delete();
      for (int b = 0; b < nb; b++) begin
         for (int k = 0; k < DDR_W / 32; k++) w[k*32 +: 32] = $urandom;
         beats.push_back(w);
      end
      // reference: segment i belongs to run i/len; runs rotate over groups
      for (int i = 0; i < seg; i++) begin
         int run;
         run    = i / len;
         e.sel  = 2'(run % (gn + 1));
         e.addr = 8'(st + (run / (gn + 1)) * len + i % len);
         w      = beats[i / SEG];
         e.data = w[(i % SEG) * BUF_W +: BUF_W];
         expq.push_back(e);
      end
      idx = 0; acc_cnt = 0; first_acc = -1; ready_seen = 0;
      first_wr = -1; last_wr = -1; wr_cnt = 0;
      mode = md; drv_en = 1;
      @(posedge clk);
      #1;
      conf_st_addr = 8'(st); conf_grp_len = 8'(len);
      conf_grp_num = 2'(gn); conf_seg_num = 16'(seg);
      start = 1;
      @(negedge clk);
      scyc = cyc;
      @(posedge clk);
      #1;
      start = 0;
      conf_st_addr = 8'($urandom); conf_grp_len = 8'($urandom);
      conf_grp_num = 2'($urandom); conf_seg_num = 16'($urandom);
   endtask

   task automatic finish_run(int seg, int md);
      int t = 0;
      int nb;
      nb = (seg + SEG - 1) / SEG;
      do begin
         @(negedge clk);
         t++;
      end while (!done && t < 3000);
      if (!done) begin
         vecs++; errs++;
         $display("FAIL done_timeout seg=%0d", seg);
      end else begin
         if (seg > 0) begin
            chk("done_after_last", BUF_W'(cyc), BUF_W'(last_wr + 1));
            chk("first_latency", BUF_W'(first_wr), BUF_W'(first_acc + 2));
            if (md == 0)
               chk("gap_free", BUF_W'(last_wr - first_wr + 1), BUF_W'(seg));
         end else begin
            chk("zero_done_time", BUF_W'(cyc), BUF_W'(scyc + 1));
            chk("zero_ready", BUF_W'(ready_seen), 0);
         end
         chk("write_count", BUF_W'(wr_cnt), BUF_W'(seg));
         chk("beat_count", BUF_W'(acc_cnt), BUF_W'(nb));
         chk("sb_empty", BUF_W'(expq.size()), 0);
         @(negedge clk);
         chk("done_pulse", BUF_W'(done), 0);
      end
      drv_en = 0;
      expq.delete();
   endtask

   task automatic run_test(int st, int len, int gn, int seg, int md,
                           bit extra);
      launch(st, len, gn, seg, md);
      if (extra) begin
         repeat (3) @(posedge clk);
         #1;
         start = 1;
         @(posedge clk);
         #1;
         start = 0;
      end
      finish_run(seg, md);
   endtask

   task automatic chk_reset_outs(string tag);
      chk({tag, "_wr_en"}, BUF_W'(buf_wr_en), 0);
      chk({tag, "_sel"},   BUF_W'(buf_wr_sel), 0);
      chk({tag, "_addr"},  BUF_W'(buf_wr_addr), 0);
      chk({tag, "_data"},  buf_wr_data, 0);
      chk({tag, "_done"},  BUF_W'(done), 0);
      chk({tag, "_ready"}, BUF_W'(ddr_ready), 0);
`ifdef DDR2PE_STALL_CNT_EN
      chk({tag, "_stall"}, BUF_W'(stall_cnt), 0);
`endif
   endtask

   initial begin
      int t;
      bit seen_done;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outs("reset");
      rst = 1;

      run_test(0, 4, 3, 16, 0, 0);
`ifdef DDR2PE_STALL_CNT_EN
      chk("stall_t1", BUF_W'(stall_cnt), 0);
`endif
      run_test(0, 4, 3, 6, 0, 0);
      run_test(8, 2, 1, 8, 0, 0);
      run_test(3, 5, 2, 32, 1, 0);
      run_test(0, 1, 0, 0, 0, 0);
      run_test(10, 3, 3, 20, 2, 1);

      // reset in the middle of the second beat
      launch(0, 4, 3, 16, 0);
      t = 0;
      while (acc_cnt < 2 && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("mid_reset_reach", BUF_W'(acc_cnt >= 2), 1);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 0;
      drv_en = 0;
      expq.delete();
      #1;
      chk_reset_outs("midrst");
      @(posedge clk);
      #2;
      rst = 1;
      seen_done = 0;
      repeat (4) begin
         @(negedge clk);
         if (done) seen_done = 1;
      end
      chk("midrst_no_done", BUF_W'(seen_done), 0);
      run_test(0, 4, 3, 4, 0, 0);

      for (int r = 0; r < 8; r++)
         run_test($urandom_range(0, 255), $urandom_range(1, 16),
                  $urandom_range(0, 3), $urandom_range(1, 40),
                  (r % 2) ? 2 : 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
